// File: rtl/wb_cmd_master_if.sv
// Command/response handshake plus Wishbone classic initiator signals of wb_cmd_master.
// master = the command master block, slave = whoever issues commands and models the bus slave.
interface wb_cmd_master_if;
  logic        cmd_val;
  logic        cmd_rdy;
  logic        cmd_we;
  logic [31:0] cmd_adr;
  logic [31:0] cmd_dat;
  logic [3:0]  cmd_sel;
  logic        rsp_val;
  logic        rsp_rdy;
  logic [31:0] rsp_dat;
  logic        rsp_err;
  logic        wbm_cyc_o;
  logic        wbm_stb_o;
  logic        wbm_we_o;
  logic [3:0]  wbm_sel_o;
  logic [31:0] wbm_adr_o;
  logic [31:0] wbm_dat_o;
  logic        wbm_ack_i;
  logic [31:0] wbm_dat_i;

  modport master (
    input  cmd_val, cmd_we, cmd_adr, cmd_dat, cmd_sel, rsp_rdy, wbm_ack_i, wbm_dat_i,
    output cmd_rdy, rsp_val, rsp_dat, rsp_err,
    output wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o
  );

  modport slave (
    output cmd_val, cmd_we, cmd_adr, cmd_dat, cmd_sel, rsp_rdy, wbm_ack_i, wbm_dat_i,
    input  cmd_rdy, rsp_val, rsp_dat, rsp_err,
    input  wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o
  );
endinterface

// File: rtl/wb_cmd_master.sv
// Wishbone classic single-transfer initiator; rsp_val rises one cycle after ACK (or timeout).
// Backpressure: one command in flight; cmd_rdy stays low until the response is taken by rsp_rdy.
module wb_cmd_master #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 16
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  wb_cmd_master_if.master  bus,
  output logic [CNT_W-1:0] txn_cnt,
  output logic [7:0]       err_cnt
);

  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

  typedef struct packed {
    logic        we;
    logic [3:0]  sel;
    logic [31:0] adr;
    logic [31:0] dat;
  } req_t;

  typedef struct packed {
    logic        err;
    logic [31:0] dat;
  } rsp_t;

  state_t           state_q, state_d;
  logic [TW-1:0]    timer_q, timer_d;
  logic             cyc_q, cyc_d;
  req_t             req_q, req_d;
  logic             rsp_val_q, rsp_val_d;
  rsp_t             rsp_q, rsp_d;
  logic [CNT_W-1:0] txn_q, txn_d;
  logic [7:0]       err_q, err_d;

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    cyc_d     = cyc_q;
    req_d     = req_q;
    rsp_val_d = rsp_val_q;
    rsp_d     = rsp_q;
    txn_d     = txn_q;
    err_d     = err_q;
    case (state_q)
      IDLE: begin
        if (bus.cmd_val) begin
          req_d   = '{we: bus.cmd_we, sel: bus.cmd_sel, adr: bus.cmd_adr, dat: bus.cmd_dat};
          cyc_d   = 1'b1;
          timer_d = '0;
          state_d = BUS;
        end
      end
      BUS: begin
        // ACK is checked first so that an ACK on the last allowed cycle still completes normally
        if (bus.wbm_ack_i) begin
          cyc_d     = 1'b0;
          rsp_d     = '{err: 1'b0, dat: req_q.we ? 32'h0 : bus.wbm_dat_i};
          rsp_val_d = 1'b1;
          txn_d     = txn_q + CNT_W'(1);
          state_d   = RESP;
        end else if (timer_q == TW'(TIMEOUT - 1)) begin
          cyc_d     = 1'b0;
          rsp_d     = '{err: 1'b1, dat: 32'h0};
          rsp_val_d = 1'b1;
          err_d     = (err_q == 8'hFF) ? err_q : err_q + 8'd1;
          state_d   = RESP;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      RESP: begin
        if (bus.rsp_rdy) begin
          rsp_val_d = 1'b0;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q   <= IDLE;
      timer_q   <= '0;
      cyc_q     <= 1'b0;
      req_q     <= '0;
      rsp_val_q <= 1'b0;
      rsp_q     <= '0;
      txn_q     <= '0;
      err_q     <= '0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      cyc_q     <= cyc_d;
      req_q     <= req_d;
      rsp_val_q <= rsp_val_d;
      rsp_q     <= rsp_d;
      txn_q     <= txn_d;
      err_q     <= err_d;
    end
  end

  assign bus.cmd_rdy   = (state_q == IDLE) && !wb_rst_i;
  assign bus.wbm_cyc_o = cyc_q;
  assign bus.wbm_stb_o = cyc_q;
  assign bus.wbm_we_o  = req_q.we;
  assign bus.wbm_sel_o = req_q.sel;
  assign bus.wbm_adr_o = req_q.adr;
  assign bus.wbm_dat_o = req_q.dat;
  assign bus.rsp_val   = rsp_val_q;
  assign bus.rsp_dat   = rsp_q.dat;
  assign bus.rsp_err   = rsp_q.err;
  assign txn_cnt       = txn_q;
  assign err_cnt       = err_q;

endmodule

// File: tb/tb_wb_cmd_master.sv
// Directed bench for wb_cmd_master: bench acts as command source and as a registered-ACK slave.
module tb_wb_cmd_master;
  localparam int TIMEOUT = 16;
  localparam int CNT_W   = 3;

  logic             wb_clk_i = 1'b0;
  logic             wb_rst_i;
  logic [CNT_W-1:0] txn_cnt;
  logic [7:0]       err_cnt;

  int               checks = 0;
  int               errors = 0;
  logic [CNT_W-1:0] exp_txn;
  logic [7:0]       exp_err;

  wb_cmd_master_if bus();

  wb_cmd_master #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .wb_clk_i (wb_clk_i),
    .wb_rst_i (wb_rst_i),
    .bus      (bus),
    .txn_cnt  (txn_cnt),
    .err_cnt  (err_cnt)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  task automatic tick();
    @(posedge wb_clk_i);
    #1;
  endtask

  task automatic drive_idle();
    bus.cmd_val   = 1'b0;
    bus.cmd_we    = 1'b0;
    bus.cmd_adr   = 32'h0;
    bus.cmd_dat   = 32'h0;
    bus.cmd_sel   = 4'h0;
    bus.rsp_rdy   = 1'b0;
    bus.wbm_ack_i = 1'b0;
    bus.wbm_dat_i = 32'h0;
  endtask

  // Presents one command for exactly one edge; returns 1 time unit after that edge
  task automatic issue(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                       input logic [3:0] sel);
    bus.cmd_we  = we;
    bus.cmd_adr = adr;
    bus.cmd_dat = dat;
    bus.cmd_sel = sel;
    bus.cmd_val = 1'b1;
    tick();
    bus.cmd_val = 1'b0;
  endtask

  task automatic run_ack(input logic [31:0] adr);
    issue(1'b1, adr, 32'hCAFE_0000, 4'hF);
    tick();
    bus.wbm_ack_i = 1'b1;
    tick();
    bus.wbm_ack_i = 1'b0;
    bus.rsp_rdy   = 1'b1;
    tick();
    bus.rsp_rdy   = 1'b0;
  endtask

  task automatic run_timeout();
    issue(1'b0, 32'h3000_0200, 32'h0, 4'hF);
    repeat (TIMEOUT) tick();
    bus.rsp_rdy = 1'b1;
    tick();
    bus.rsp_rdy = 1'b0;
  endtask

  task automatic test_reset();
    drive_idle();
    wb_rst_i = 1'b1;
    tick();
    tick();
    checks++;
    if (bus.cmd_rdy !== 1'b0) begin
      errors++; $display("FAIL reset_cmd_rdy: got %b want 0", bus.cmd_rdy);
    end
    checks++;
    if ({bus.wbm_cyc_o, bus.wbm_stb_o, bus.wbm_we_o, bus.wbm_sel_o, bus.wbm_adr_o,
         bus.wbm_dat_o} !== 71'h0) begin
      errors++; $display("FAIL reset_wb_outputs: cyc=%b stb=%b we=%b sel=%h adr=%h dat=%h want all 0",
                         bus.wbm_cyc_o, bus.wbm_stb_o, bus.wbm_we_o, bus.wbm_sel_o, bus.wbm_adr_o, bus.wbm_dat_o);
    end
    checks++;
    if ({bus.rsp_val, bus.rsp_err, bus.rsp_dat, txn_cnt, err_cnt} !== {2'b00, 32'h0, {CNT_W{1'b0}}, 8'h0}) begin
      errors++; $display("FAIL reset_rsp_counters: val=%b err=%b dat=%h txn=%0d errc=%0d want all 0",
                         bus.rsp_val, bus.rsp_err, bus.rsp_dat, txn_cnt, err_cnt);
    end
    wb_rst_i = 1'b0;
    #1;
    checks++;
    if (bus.cmd_rdy !== 1'b1) begin
      errors++; $display("FAIL reset_release_cmd_rdy: got %b want 1", bus.cmd_rdy);
    end
    exp_txn = '0;
    exp_err = 8'h0;
  endtask

  task automatic test_write();
    bus.wbm_dat_i = 32'hDEAD_BEEF;
    issue(1'b1, 32'h3000_0000, 32'h0000_1234, 4'hF);
    checks++;
    if ({bus.wbm_cyc_o, bus.wbm_stb_o, bus.wbm_we_o, bus.wbm_adr_o, bus.wbm_dat_o, bus.wbm_sel_o}
        !== {3'b111, 32'h3000_0000, 32'h0000_1234, 4'hF}) begin
      errors++; $display("FAIL write_launch: cyc=%b stb=%b we=%b adr=%h dat=%h sel=%h want 1 1 1 30000000 00001234 f",
                         bus.wbm_cyc_o, bus.wbm_stb_o, bus.wbm_we_o, bus.wbm_adr_o, bus.wbm_dat_o, bus.wbm_sel_o);
    end
    checks++;
    if ({bus.cmd_rdy, bus.rsp_val} !== 2'b00) begin
      errors++; $display("FAIL write_busy: cmd_rdy=%b rsp_val=%b want 0 0", bus.cmd_rdy, bus.rsp_val);
    end
    tick();
    bus.wbm_ack_i = 1'b1;
    checks++;
    if ({bus.wbm_stb_o, bus.rsp_val} !== 2'b10) begin
      errors++; $display("FAIL write_edge1: stb=%b rsp_val=%b want 1 0", bus.wbm_stb_o, bus.rsp_val);
    end
    tick();
    bus.wbm_ack_i = 1'b0;
    exp_txn++;
    checks++;
    if ({bus.wbm_cyc_o, bus.wbm_stb_o, bus.rsp_val, bus.rsp_err, bus.rsp_dat} !== {4'b0010, 32'h0}) begin
      errors++; $display("FAIL write_resp: cyc=%b stb=%b val=%b err=%b dat=%h want 0 0 1 0 00000000",
                         bus.wbm_cyc_o, bus.wbm_stb_o, bus.rsp_val, bus.rsp_err, bus.rsp_dat);
    end
    checks++;
    if (txn_cnt !== exp_txn) begin
      errors++; $display("FAIL write_txn_cnt: got %0d want %0d", txn_cnt, exp_txn);
    end
    bus.rsp_rdy = 1'b1;
    tick();
    bus.rsp_rdy = 1'b0;
    checks++;
    if ({bus.rsp_val, bus.cmd_rdy} !== 2'b01) begin
      errors++; $display("FAIL write_handshake: rsp_val=%b cmd_rdy=%b want 0 1", bus.rsp_val, bus.cmd_rdy);
    end
  endtask

  task automatic test_read();
    bus.wbm_dat_i = 32'h0000_ABCD;
    issue(1'b0, 32'h3000_0004, 32'hFFFF_FFFF, 4'h3);
    checks++;
    if ({bus.wbm_cyc_o, bus.wbm_we_o, bus.wbm_adr_o, bus.wbm_sel_o} !== {2'b10, 32'h3000_0004, 4'h3}) begin
      errors++; $display("FAIL read_launch: cyc=%b we=%b adr=%h sel=%h want 1 0 30000004 3",
                         bus.wbm_cyc_o, bus.wbm_we_o, bus.wbm_adr_o, bus.wbm_sel_o);
    end
    tick();
    bus.wbm_ack_i = 1'b1;
    checks++;
    if ({bus.wbm_cyc_o, bus.wbm_we_o} !== 2'b10) begin
      errors++; $display("FAIL read_hold: cyc=%b we=%b want 1 0", bus.wbm_cyc_o, bus.wbm_we_o);
    end
    tick();
    bus.wbm_ack_i = 1'b0;
    exp_txn++;
    checks++;
    if ({bus.rsp_val, bus.rsp_err, bus.rsp_dat, bus.wbm_we_o} !== {2'b10, 32'h0000_ABCD, 1'b0}) begin
      errors++; $display("FAIL read_resp: val=%b err=%b dat=%h we=%b want 1 0 0000abcd 0",
                         bus.rsp_val, bus.rsp_err, bus.rsp_dat, bus.wbm_we_o);
    end
    checks++;
    if (txn_cnt !== exp_txn) begin
      errors++; $display("FAIL read_txn_cnt: got %0d want %0d", txn_cnt, exp_txn);
    end
    bus.rsp_rdy = 1'b1;
    tick();
    bus.rsp_rdy = 1'b0;
  endtask

  task automatic test_timeout();
    int n;
    n = 0;
    bus.wbm_dat_i = 32'h5555_AAAA;
    issue(1'b0, 32'h3000_0008, 32'h0, 4'hF);
    for (int i = 0; i < 3 * TIMEOUT && bus.wbm_stb_o === 1'b1; i++) begin
      tick();
      n++;
    end
    exp_err++;
    checks++;
    if (n != TIMEOUT) begin
      errors++; $display("FAIL timeout_stb_cycles: got %0d want %0d", n, TIMEOUT);
    end
    checks++;
    if ({bus.rsp_val, bus.rsp_err, bus.rsp_dat, bus.wbm_cyc_o} !== {2'b11, 32'h0, 1'b0}) begin
      errors++; $display("FAIL timeout_resp: val=%b err=%b dat=%h cyc=%b want 1 1 00000000 0",
                         bus.rsp_val, bus.rsp_err, bus.rsp_dat, bus.wbm_cyc_o);
    end
    checks++;
    if ({err_cnt, txn_cnt} !== {exp_err, exp_txn}) begin
      errors++; $display("FAIL timeout_counters: err_cnt=%0d txn_cnt=%0d want %0d %0d",
                         err_cnt, txn_cnt, exp_err, exp_txn);
    end
    bus.rsp_rdy = 1'b1;
    tick();
    bus.rsp_rdy = 1'b0;
  endtask

  task automatic test_ack_last();
    bus.wbm_dat_i = 32'h0BAD_F00D;
    issue(1'b0, 32'h3000_000C, 32'h0, 4'hF);
    repeat (TIMEOUT - 1) tick();
    checks++;
    if (bus.wbm_stb_o !== 1'b1) begin
      errors++; $display("FAIL ack_last_stb_still_high: got %b want 1", bus.wbm_stb_o);
    end
    bus.wbm_ack_i = 1'b1;
    tick();
    bus.wbm_ack_i = 1'b0;
    exp_txn++;
    checks++;
    if ({bus.rsp_val, bus.rsp_err, bus.rsp_dat} !== {2'b10, 32'h0BAD_F00D}) begin
      errors++; $display("FAIL ack_last_resp: val=%b err=%b dat=%h want 1 0 0badf00d",
                         bus.rsp_val, bus.rsp_err, bus.rsp_dat);
    end
    checks++;
    if ({txn_cnt, err_cnt} !== {exp_txn, exp_err}) begin
      errors++; $display("FAIL ack_last_counters: txn_cnt=%0d err_cnt=%0d want %0d %0d",
                         txn_cnt, err_cnt, exp_txn, exp_err);
    end
    bus.rsp_rdy = 1'b1;
    tick();
    bus.rsp_rdy = 1'b0;
  endtask

  task automatic test_back_to_back();
    bus.wbm_dat_i = 32'h9999_9999;
    bus.cmd_we  = 1'b1;
    bus.cmd_adr = 32'h3000_0010;
    bus.cmd_dat = 32'h1111_1111;
    bus.cmd_sel = 4'hF;
    bus.cmd_val = 1'b1;
    tick();
    // second command waits on the port for the whole first transfer
    bus.cmd_we  = 1'b0;
    bus.cmd_adr = 32'h3000_0014;
    bus.cmd_dat = 32'h0;
    bus.cmd_sel = 4'h1;
    checks++;
    if ({bus.wbm_we_o, bus.wbm_adr_o, bus.wbm_dat_o} !== {1'b1, 32'h3000_0010, 32'h1111_1111}) begin
      errors++; $display("FAIL b2b_latched: we=%b adr=%h dat=%h want 1 30000010 11111111",
                         bus.wbm_we_o, bus.wbm_adr_o, bus.wbm_dat_o);
    end
    tick();
    bus.wbm_ack_i = 1'b1;
    tick();
    bus.wbm_ack_i = 1'b0;
    exp_txn++;
    for (int i = 0; i < 10; i++) begin
      checks++;
      if ({bus.rsp_val, bus.rsp_err, bus.rsp_dat, bus.cmd_rdy, bus.wbm_cyc_o} !== {2'b10, 32'h0, 2'b00}) begin
        errors++; $display("FAIL b2b_stall_%0d: val=%b err=%b dat=%h cmd_rdy=%b cyc=%b want 1 0 00000000 0 0",
                           i, bus.rsp_val, bus.rsp_err, bus.rsp_dat, bus.cmd_rdy, bus.wbm_cyc_o);
      end
      tick();
    end
    bus.rsp_rdy = 1'b1;
    tick();
    bus.rsp_rdy = 1'b0;
    checks++;
    if ({bus.rsp_val, bus.wbm_cyc_o, bus.cmd_rdy} !== 3'b001) begin
      errors++; $display("FAIL b2b_after_handshake: val=%b cyc=%b cmd_rdy=%b want 0 0 1",
                         bus.rsp_val, bus.wbm_cyc_o, bus.cmd_rdy);
    end
    tick();
    bus.cmd_val = 1'b0;
    checks++;
    if ({bus.wbm_cyc_o, bus.wbm_we_o, bus.wbm_adr_o, bus.wbm_sel_o} !== {2'b10, 32'h3000_0014, 4'h1}) begin
      errors++; $display("FAIL b2b_second_accept: cyc=%b we=%b adr=%h sel=%h want 1 0 30000014 1",
                         bus.wbm_cyc_o, bus.wbm_we_o, bus.wbm_adr_o, bus.wbm_sel_o);
    end
    bus.wbm_dat_i = 32'h7777_0001;
    tick();
    bus.wbm_ack_i = 1'b1;
    tick();
    bus.wbm_ack_i = 1'b0;
    exp_txn++;
    checks++;
    if ({bus.rsp_val, bus.rsp_dat, txn_cnt} !== {1'b1, 32'h7777_0001, exp_txn}) begin
      errors++; $display("FAIL b2b_second_resp: val=%b dat=%h txn=%0d want 1 77770001 %0d",
                         bus.rsp_val, bus.rsp_dat, txn_cnt, exp_txn);
    end
    bus.rsp_rdy = 1'b1;
    tick();
    bus.rsp_rdy = 1'b0;
  endtask

  task automatic test_bus_reset();
    issue(1'b1, 32'h3000_0020, 32'h2222_2222, 4'hF);
    tick();
    wb_rst_i = 1'b1;
    tick();
    checks++;
    if ({bus.wbm_cyc_o, bus.wbm_stb_o, bus.rsp_val, bus.cmd_rdy} !== 4'b0000) begin
      errors++; $display("FAIL bus_reset_outputs: cyc=%b stb=%b val=%b cmd_rdy=%b want 0 0 0 0",
                         bus.wbm_cyc_o, bus.wbm_stb_o, bus.rsp_val, bus.cmd_rdy);
    end
    checks++;
    if ({txn_cnt, err_cnt} !== {{CNT_W{1'b0}}, 8'h0}) begin
      errors++; $display("FAIL bus_reset_counters: txn=%0d err=%0d want 0 0", txn_cnt, err_cnt);
    end
    wb_rst_i = 1'b0;
    exp_txn  = '0;
    exp_err  = 8'h0;
    bus.wbm_ack_i = 1'b1;
    tick();
    tick();
    bus.wbm_ack_i = 1'b0;
    tick();
    checks++;
    if ({bus.wbm_cyc_o, bus.rsp_val, bus.cmd_rdy, txn_cnt, err_cnt} !== {3'b001, exp_txn, exp_err}) begin
      errors++; $display("FAIL stray_ack_idle: cyc=%b val=%b cmd_rdy=%b txn=%0d err=%0d want 0 0 1 0 0",
                         bus.wbm_cyc_o, bus.rsp_val, bus.cmd_rdy, txn_cnt, err_cnt);
    end
  endtask

  task automatic test_txn_wrap();
    for (int i = 0; i < 7; i++) begin
      run_ack(32'h3000_0100 + 32'(i));
      exp_txn++;
    end
    checks++;
    if (txn_cnt !== {CNT_W{1'b1}}) begin
      errors++; $display("FAIL txn_all_ones: got %0d want %0d", txn_cnt, exp_txn);
    end
    run_ack(32'h3000_0180);
    exp_txn++;
    checks++;
    if (txn_cnt !== exp_txn) begin
      errors++; $display("FAIL txn_wrap: got %0d want %0d", txn_cnt, exp_txn);
    end
  endtask

  task automatic test_err_saturate();
    for (int i = 0; i < 255; i++) begin
      run_timeout();
      exp_err++;
    end
    checks++;
    if (err_cnt !== 8'hFF) begin
      errors++; $display("FAIL err_reach_max: got %h want ff", err_cnt);
    end
    run_timeout();
    checks++;
    if ({err_cnt, txn_cnt} !== {exp_err, exp_txn}) begin
      errors++; $display("FAIL err_saturate: err=%h txn=%0d want %h %0d", err_cnt, txn_cnt, exp_err, exp_txn);
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_timeout();
    test_ack_last();
    test_back_to_back();
    test_bus_reset();
    test_txn_wrap();
    test_err_saturate();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule
